// File: rtl/cv32e40px_apu_disp_q_if.sv
// APU interconnect handshake between the dispatcher and the APU.
// The dispatcher drives req; the APU answers with gnt and rvalid.
interface cv32e40px_apu_disp_q_if;
    logic req;
    logic gnt;
    logic rvalid;

    modport master (output req, input gnt, input rvalid);
    modport slave  (input req, output gnt, output rvalid);
endinterface

// File: rtl/cv32e40px_apu_disp_q.sv
// APU dispatcher with a DEPTH-deep in-order write-back address queue.
// It raises read/write dependency stalls against every queued destination.
module cv32e40px_apu_disp_q #(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned N_READ  = 3,
    parameter int unsigned N_WRITE = 2,
    parameter int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    cv32e40px_apu_disp_q_if.master          apu,
    input  logic                            enable_i,
    input  logic [1:0]                      apu_lat_i,
    input  logic [ADDR_W-1:0]               apu_waddr_i,
    output logic [ADDR_W-1:0]               apu_waddr_o,
    output logic                            apu_multicycle_o,
    output logic                            apu_singlecycle_o,
    output logic                            active_o,
    output logic [CNT_W-1:0]                count_o,
    output logic                            stall_o,
    input  logic                            is_decoding_i,
    input  logic [N_READ-1:0][ADDR_W-1:0]   read_regs_i,
    input  logic [N_READ-1:0]               read_regs_valid_i,
    output logic                            read_dep_o,
    output logic                            read_dep_for_jalr_o,
    input  logic [N_WRITE-1:0][ADDR_W-1:0]  write_regs_i,
    input  logic [N_WRITE-1:0]              write_regs_valid_i,
    output logic                            write_dep_o,
    output logic                            perf_type_o,
    output logic                            perf_cont_o,
    output logic                            spurious_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        lat_q, lat_d;

    logic empty, stall_full, stall_type, stall_nack, valid_req;
    logic returned_head, returned_req, push, pop;
    logic req_rd, req_wr;
    logic [DEPTH-1:0] ent_rd, ent_wr, head_excl;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign empty      = (cnt_q == '0);
    assign stall_full = (cnt_q == FULL);
    assign stall_type = enable_i & !empty &
                        ((apu_lat_i == 2'd1) |
                         ((apu_lat_i == 2'd2) & (lat_q == 2'd3)) |
                         (apu_lat_i == 2'd3));
    assign valid_req  = enable_i & !stall_full & !stall_type;
    assign stall_nack = valid_req & !apu.gnt;

    assign returned_head = apu.rvalid & !empty;
    assign returned_req  = valid_req & apu.rvalid & empty;
    assign push = valid_req & apu.gnt & !returned_req;
    assign pop  = returned_head;

    assign apu.req           = valid_req;
    assign stall_o           = stall_full | stall_type | stall_nack;
    assign perf_type_o       = stall_type;
    assign perf_cont_o       = stall_nack;
    assign active_o          = !empty;
    assign apu_singlecycle_o = empty;
    assign apu_multicycle_o  = (lat_q == 2'd3);
    assign count_o           = cnt_q;
    assign spurious_o        = apu.rvalid & empty & !valid_req;

    always_comb begin
        apu_waddr_o = '0;
        if (returned_head) begin
            apu_waddr_o = addr_q[rptr_q];
        end else if (returned_req) begin
            apu_waddr_o = apu_waddr_i;
        end
    end

    always_comb begin
        req_rd = 1'b0;
        req_wr = 1'b0;
        ent_rd = '0;
        ent_wr = '0;
        for (int r = 0; r < int'(N_READ); r++) begin
            req_rd = req_rd | (read_regs_valid_i[r] &
                               (read_regs_i[r] == apu_waddr_i));
            for (int e = 0; e < int'(DEPTH); e++) begin
                ent_rd[e] = ent_rd[e] | (read_regs_valid_i[r] &
                                         (read_regs_i[r] == addr_q[e]));
            end
        end
        for (int w = 0; w < int'(N_WRITE); w++) begin
            req_wr = req_wr | (write_regs_valid_i[w] &
                               (write_regs_i[w] == apu_waddr_i));
            for (int e = 0; e < int'(DEPTH); e++) begin
                ent_wr[e] = ent_wr[e] | (write_regs_valid_i[w] &
                                         (write_regs_i[w] == addr_q[e]));
            end
        end
    end

    // The head retiring this cycle no longer blocks the decoder.
    always_comb begin
        head_excl = '0;
        if (returned_head) head_excl[rptr_q] = 1'b1;
    end

    assign read_dep_o = is_decoding_i &
                        ((|(ent_rd & vld_q & ~head_excl)) |
                         (valid_req & !returned_req & req_rd));
    assign write_dep_o = is_decoding_i &
                         ((|(ent_wr & vld_q & ~head_excl)) |
                          (valid_req & !returned_req & req_wr));
    assign read_dep_for_jalr_o = is_decoding_i &
                                 ((enable_i & req_rd) | (|(ent_rd & vld_q)));

    always_comb begin
        addr_d = addr_q;
        vld_d  = vld_q;
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        lat_d  = lat_q;
        if (valid_req) lat_d = apu_lat_i;
        if (pop) begin
            vld_d[rptr_q] = 1'b0;
            rptr_d        = ptr_inc(rptr_q);
        end
        if (push) begin
            addr_d[wptr_q] = apu_waddr_i;
            vld_d[wptr_q]  = 1'b1;
            wptr_d         = ptr_inc(wptr_q);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int e = 0; e < int'(DEPTH); e++) addr_q[e] <= '0;
            vld_q  <= '0;
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
            lat_q  <= '0;
        end else begin
            addr_q <= addr_d;
            vld_q  <= vld_d;
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
            lat_q  <= lat_d;
        end
    end
endmodule

// File: doc/cv32e40px_apu_disp_q.md
# cv32e40px_apu_disp_q

Parametrised APU dispatcher for the cv32e40px core: issues requests to the APU interconnect and tracks up to DEPTH outstanding operations in an in-order address queue. It raises register read/write dependency stalls against every queued destination and steers each response to its write-back address. It sits between the ID/EX stage and the APU master port and generalises the fixed two-slot dispatcher. It adds a configurable queue depth, configurable port counts and widths, an occupancy output and a spurious-response flag.

## Interface
- DEPTH, default 2: maximum outstanding multicycle operations; must be ≥1.
- ADDR_W, default 6: register address width.
- N_READ, default 3: read-register ports checked for dependencies.
- N_WRITE, default 2: write-register ports checked for dependencies.
- CNT_W, default $clog2(DEPTH+1): width of the occupancy output.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- enable_i  in  1  an APU instruction wants to issue.
- apu_lat_i  in  2  latency class of that instruction: 1, 2, or 3 (3 = multicycle).
- apu_waddr_i  in  ADDR_W  destination of that instruction.
- apu_waddr_o  out  ADDR_W  write-back address of the returning result.
- apu_multicycle_o  out  1  last latched latency class is 3.
- apu_singlecycle_o  out  1  queue is empty.
- active_o  out  1  queue is non-empty.
- count_o  out  CNT_W  queue occupancy.
- stall_o  out  1  stall_full | stall_type | stall_nack.
- is_decoding_i  in  1  ID stage is decoding.
- read_regs_i / read_regs_valid_i  in  N_READ×ADDR_W / N_READ  source registers and their valid bits.
- read_dep_o, read_dep_for_jalr_o  out  1  read dependency flags.
- write_regs_i / write_regs_valid_i  in  N_WRITE×ADDR_W / N_WRITE  destination registers and their valid bits.
- write_dep_o  out  1  write dependency flag.
- perf_type_o, perf_cont_o  out  1  type-stall and nack-stall events.
- spurious_o  out  1  response received with nothing outstanding.
- apu_req_o  out  1  request to the interconnect; apu_gnt_i  in  1  grant.
- apu_rvalid_i  in  1  response valid; responses return in issue order.

## Operation
- Stall and request terms:
  - stall_full = (count == DEPTH).
  - stall_type = enable_i & active & (lat_i==1 | (lat_i==2 & lat_q==3) | lat_i==3).
  - valid_req = enable_i & !stall_full & !stall_type; apu_req_o = valid_req.
  - stall_nack = valid_req & !apu_gnt_i.
- Latency register: lat_q ← apu_lat_i whenever valid_req. Reset value 0.
- Return detection:
  - returned_head = apu_rvalid_i & !empty.
  - returned_req = valid_req & apu_rvalid_i & empty. This is a single-cycle op and is never enqueued.
- Queue actions:
  - push when valid_req & apu_gnt_i & !returned_req.
  - pop when returned_head.
  - Push and pop in the same cycle: count is unchanged, head advances, the new entry goes to the tail.
  - The queue is a circular buffer with read and write pointers that wrap at DEPTH (not a power of 2 in general).
- apu_waddr_o:
  - head address if returned_head;
  - else apu_waddr_i if returned_req;
  - else 0.
- Per-entry dependency: an entry counts if it is valid, its address matches a valid read/write port, and it is not the head while returned_head is true. The request term is valid_req & !returned_req & match.
- Dependency outputs:
  - read_dep_o = is_decoding_i & OR over entries and the request term, using read ports.
  - write_dep_o = same form, using write ports.
  - read_dep_for_jalr_o = is_decoding_i & ((enable_i & req match) | any valid entry match). It ignores the return exclusion.
- spurious_o = apu_rvalid_i & empty & !valid_req. This is a combinational pulse; no state changes.
- perf_type_o = stall_type; perf_cont_o = stall_nack.

## Timing
- Reset values: queue empty, count_o=0, lat_q=0, active_o=0, apu_singlecycle_o=1, apu_multicycle_o=0. All other outputs are combinational and are 0 when inputs are idle.
- All outputs are combinational from the inputs and the registered state. Queue and lat_q update on the rising clk_i edge.
- A response in the same cycle as the grant, with the queue empty, writes back in that cycle with zero added latency.
- When full, a pop frees a slot only from the next cycle; stall_full does not look ahead.
- An asynchronous reset mid-operation discards all entries immediately. Responses arriving after reset raise spurious_o.

## Test plan
- DEPTH=4: issue 4 grants with lat_i=2 to addr 5, 6, 7, 8 and no rvalid. Required: count_o=4 and stall_o=1 on a fifth enable_i. Then 4 rvalids give apu_waddr_o 5, 6, 7, 8 in order, and count_o returns to 0.
- Queue empty, enable_i with gnt and rvalid in the same cycle, addr 9. Required: apu_waddr_o=9, count_o stays 0, no read_dep_o on reg 9 in that cycle.
- Queue has addr 3 at count 2; push addr 4 and rvalid in the same cycle. Required: waddr_o=3, count stays 2, and the next rvalid yields the second entry.
- Queue holds addr 12; is_decoding_i=1 with read_regs_i[1]=12 valid. Required: read_dep_o=1. With rvalid the same cycle, read_dep_o=0 but read_dep_for_jalr_o=1.
- Active with lat_q=3 and enable_i with lat_i=2. Required: stall_o=1, perf_type_o=1, apu_req_o=0. With gnt low on a legal request, perf_cont_o=1.
- rvalid with queue empty and no request. Required: spurious_o=1 and count_o stays 0. Repeat 3 wrap-arounds at DEPTH=3 with order preserved.
